// File: rtl/instruction_decode_if.sv
// Decode-stage bus: the instruction and writeback inputs, plus the decoded controls,
// the operands, the immediate and the branch resolution.
interface instruction_decode_if;
  logic [31:0] Instruction;
  logic [63:0] PC;
  logic        RegWriteEn;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;

  logic        PCSrc;
  logic [63:0] BranchAddress;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic [63:0] Immediate;
  logic        Reg2Loc;
  logic        ALUSrc;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic        UncondBranch;
  logic [1:0]  ALUOp;
  logic        Halt;

  modport master (
    output Instruction, PC, RegWriteEn, WriteReg, WriteData,
    input  PCSrc, BranchAddress, ReadData1, ReadData2, Immediate,
           Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, UncondBranch, ALUOp, Halt
  );

  modport slave (
    input  Instruction, PC, RegWriteEn, WriteReg, WriteData,
    output PCSrc, BranchAddress, ReadData1, ReadData2, Immediate,
           Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, UncondBranch, ALUOp, Halt
  );
endinterface

// File: rtl/instruction_decode.sv
// LEGv8-subset decode stage: opcode decode, immediate extension, the 32x64 register
// file (X31 reads as zero) and branch resolution. Only the register file is clocked.
module instruction_decode (
  input  logic                 clk,
  input  logic                 reset,
  instruction_decode_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_UNKNOWN, OP_HALT, OP_RTYPE, OP_LDUR, OP_STUR,
    OP_ADDI, OP_SUBI, OP_CBZ, OP_CBNZ, OP_B
  } op_e;

  op_e         op;
  logic [31:0] instr;
  logic [63:0] regs_q [32];
  logic [63:0] regs_d [32];

  logic        reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
  logic        branch, uncond_branch, halt;
  logic [1:0]  alu_op;
  logic [63:0] imm;
  logic [4:0]  rn, rm_sel;
  logic [63:0] read_data1, read_data2;
  logic        pc_src;

  assign instr = bus.Instruction;

  // Earlier matches win, so HALT shadows every other encoding.
  always_comb begin
    op = OP_UNKNOWN;
    if (instr[31:21] == 11'b11111111111)                   op = OP_HALT;
    else if (instr[31:21] inside {11'b10001011000, 11'b11001011000,
                                  11'b10001010000, 11'b10101010000})
                                                           op = OP_RTYPE;
    else if (instr[31:21] == 11'b11111000010)              op = OP_LDUR;
    else if (instr[31:21] == 11'b11111000000)              op = OP_STUR;
    else if (instr[31:22] == 10'b1001000100)               op = OP_ADDI;
    else if (instr[31:22] == 10'b1101000100)               op = OP_SUBI;
    else if (instr[31:24] == 8'b10110100)                  op = OP_CBZ;
    else if (instr[31:24] == 8'b10110101)                  op = OP_CBNZ;
    else if (instr[31:26] == 6'b000101)                    op = OP_B;
  end

  // NOTE: every output of a combinational block gets a default before the case, so no
  // opcode path can leave a signal unassigned and infer a latch.
  always_comb begin
    reg2loc       = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    halt          = 1'b0;
    alu_op        = 2'b00;
    imm           = '0;
    case (op)
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OP_LDUR: begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        imm        = {{55{instr[20]}}, instr[20:12]};
      end
      OP_STUR: begin
        reg2loc   = 1'b1;
        alu_src   = 1'b1;
        mem_write = 1'b1;
        imm       = {{55{instr[20]}}, instr[20:12]};
      end
      OP_ADDI, OP_SUBI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        alu_op    = 2'b11;
        imm       = {52'd0, instr[21:10]};
      end
      OP_CBZ, OP_CBNZ: begin
        reg2loc = 1'b1;
        branch  = 1'b1;
        alu_op  = 2'b01;
        imm     = {{45{instr[23]}}, instr[23:5]};
      end
      OP_B: begin
        uncond_branch = 1'b1;
        imm           = {{38{instr[25]}}, instr[25:0]};
      end
      OP_HALT: halt = 1'b1;
      default: ;
    endcase
  end

  // Stores and CB-type carry the second source in the Rt field.
  assign rn         = instr[9:5];
  assign rm_sel     = reg2loc ? instr[4:0] : instr[20:16];
  assign read_data1 = (rn == 5'd31)     ? 64'd0 : regs_q[rn];
  assign read_data2 = (rm_sel == 5'd31) ? 64'd0 : regs_q[rm_sel];

  assign pc_src = uncond_branch
                | ((op == OP_CBZ)  && (read_data2 == 64'd0))
                | ((op == OP_CBNZ) && (read_data2 != 64'd0));

  always_comb begin
    regs_d = regs_q;
    if (bus.RegWriteEn && (bus.WriteReg != 5'd31))
      regs_d[bus.WriteReg] = bus.WriteData;
  end

  // NOTE: the register file is cleared by the asynchronous reset because software
  // relies on X0..X30 reading zero after reset; a plain RAM would not get this.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.PCSrc         = pc_src;
  assign bus.BranchAddress = bus.PC + {imm[61:0], 2'b00};
  assign bus.ReadData1     = read_data1;
  assign bus.ReadData2     = read_data2;
  assign bus.Immediate     = imm;
  assign bus.Reg2Loc       = reg2loc;
  assign bus.ALUSrc        = alu_src;
  assign bus.MemtoReg      = mem_to_reg;
  assign bus.RegWrite      = reg_write;
  assign bus.MemRead       = mem_read;
  assign bus.MemWrite      = mem_write;
  assign bus.Branch        = branch;
  assign bus.UncondBranch  = uncond_branch;
  assign bus.ALUOp         = alu_op;
  assign bus.Halt          = halt;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: stimulus queues hand-computed expectations,
// a monitor compares them whenever a decode result is presented.
module tb_instruction_decode;

  logic clk;
  logic reset;

  instruction_decode_if dif ();

  instruction_decode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order: Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite Branch UncondBranch Halt
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_R    = 9'b000100000;
  localparam logic [8:0] C_LD   = 9'b011110000;
  localparam logic [8:0] C_ST   = 9'b110001000;
  localparam logic [8:0] C_IM   = 9'b010100000;
  localparam logic [8:0] C_CB   = 9'b100000100;
  localparam logic [8:0] C_B    = 9'b000000010;
  localparam logic [8:0] C_H    = 9'b000000001;

  localparam logic [63:0] X3_VAL = 64'hDEAD_BEEF_0000_0003;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [8:0]  ctrl;
    logic [1:0]  alu_op;
    logic [63:0] imm;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic        pc_src;
    logic [63:0] baddr;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(logic [31:0] i, logic [63:0] pc, logic [8:0] c,
                              logic [1:0] a, logic [63:0] im, logic [63:0] r1,
                              logic [63:0] r2, logic ps, logic [63:0] ba);
    exp_t e;
    e.instr = i;   e.pc = pc;   e.ctrl = c;  e.alu_op = a; e.imm = im;
    e.rd1   = r1;  e.rd2 = r2;  e.pc_src = ps; e.baddr = ba;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] instr, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s instr=%h got=%h expected=%h", name, instr, act, exp);
    end
  endtask

  // Monitor: every presented decode result is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output instr=%h got=output expected=none", dif.Instruction);
      end else begin
        e = sb_q.pop_front();
        check("ctrl",   e.instr, 64'({dif.Reg2Loc, dif.ALUSrc, dif.MemtoReg, dif.RegWrite,
                                      dif.MemRead, dif.MemWrite, dif.Branch,
                                      dif.UncondBranch, dif.Halt}), 64'(e.ctrl));
        check("alu_op", e.instr, 64'(dif.ALUOp), 64'(e.alu_op));
        check("imm",    e.instr, dif.Immediate, e.imm);
        check("rd1",    e.instr, dif.ReadData1, e.rd1);
        check("rd2",    e.instr, dif.ReadData2, e.rd2);
        check("pc_src", e.instr, 64'(dif.PCSrc), 64'(e.pc_src));
        check("baddr",  e.instr, dif.BranchAddress, e.baddr);
      end
    end
  end

  // Drive one instruction now, queue its expectation and present it to the monitor.
  task automatic apply(exp_t e);
    int waited;
    dif.Instruction = e.instr;
    dif.PC          = e.pc;
    #1;
    sb_q.push_back(e);
    ->sample_ev;
    waited = 0;
    while (sb_q.size() != 0 && waited < 3) begin
      #1;
      waited++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL monitor_timeout instr=%h got=pending expected=consumed", e.instr);
      sb_q.delete();
    end
  endtask

  task automatic step(exp_t e);
    @(negedge clk);
    apply(e);
  endtask

  task automatic wr(logic [4:0] r, logic [63:0] d);
    @(negedge clk);
    dif.RegWriteEn = 1'b1;
    dif.WriteReg   = r;
    dif.WriteData  = d;
    @(negedge clk);
    dif.RegWriteEn = 1'b0;
  endtask

  function automatic exp_t add_x1(logic [63:0] v);
    return mk(32'h8B010022, 64'h100, C_R, 2'b10, 64'd0, v, v, 1'b0, 64'h100);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    dif.Instruction = '0;
    dif.PC          = '0;
    dif.RegWriteEn  = 1'b0;
    dif.WriteReg    = '0;
    dif.WriteData   = '0;

    // Reset state: registers read zero, decode still active.
    step(add_x1(64'd0));
    @(negedge clk);
    reset = 1'b0;

    wr(5'd1, 64'd5);
    wr(5'd3, X3_VAL);

    step(add_x1(64'd5));
    step(mk(32'h14000003, 64'h10, C_B,  2'b00, 64'd3, 64'd0, 64'd0, 1'b1, 64'h1C));
    step(mk(32'h17FFFFFF, 64'h10, C_B,  2'b00, '1,    64'd0, 64'd0, 1'b1, 64'hC));
    step(mk(32'hB400005F, 64'h40, C_CB, 2'b01, 64'd2, 64'd0, 64'd0, 1'b1, 64'h48));
    step(mk(32'hB5FFFFC1, 64'h40, C_CB, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE,
            64'd0, 64'd5, 1'b1, 64'h38));
    step(mk(32'hB4000041, 64'h40, C_CB, 2'b01, 64'd2, 64'd0, 64'd5, 1'b0, 64'h48));
    step(mk(32'hF85F8023, 64'h100, C_LD, 2'b00, 64'hFFFF_FFFF_FFFF_FFF8,
            64'd5, 64'd0, 1'b0, 64'hE0));
    step(mk(32'hF8010023, 64'h100, C_ST, 2'b00, 64'd16, 64'd5, X3_VAL, 1'b0, 64'h140));
    step(mk(32'h913FFC24, 64'h100, C_IM, 2'b11, 64'hFFF, 64'd5, 64'd0, 1'b0, 64'h40FC));
    step(mk(32'hD1000460, 64'h100, C_IM, 2'b11, 64'd1, X3_VAL, 64'd0, 1'b0, 64'h104));
    step(mk(32'hCB010065, 64'h100, C_R,  2'b10, 64'd0, X3_VAL, 64'd5, 1'b0, 64'h100));
    step(mk(32'hAA010065, 64'h100, C_R,  2'b10, 64'd0, X3_VAL, 64'd5, 1'b0, 64'h100));
    step(mk(32'hFFE00000, 64'h200, C_H,    2'b00, 64'd0, 64'd0, 64'd0, 1'b0, 64'h200));
    step(mk(32'h00000000, 64'h200, C_NONE, 2'b00, 64'd0, 64'd0, 64'd0, 1'b0, 64'h200));

    // XZR: the write is dropped and reads stay zero.
    wr(5'd31, 64'hFF);
    step(mk(32'h8B1F03E2, 64'h100, C_R, 2'b10, 64'd0, 64'd0, 64'd0, 1'b0, 64'h100));

    // No bypass: old value before the edge, new value after it.
    @(negedge clk);
    dif.RegWriteEn = 1'b1;
    dif.WriteReg   = 5'd1;
    dif.WriteData  = 64'd7;
    apply(add_x1(64'd5));
    @(negedge clk);
    dif.RegWriteEn = 1'b0;
    apply(add_x1(64'd7));

    // Asynchronous reset between edges clears at once and blocks writes across an edge.
    @(negedge clk);
    #2;
    dif.RegWriteEn = 1'b1;
    dif.WriteData  = 64'd9;
    reset          = 1'b1;
    apply(add_x1(64'd0));
    step(add_x1(64'd0));
    reset          = 1'b0;
    dif.RegWriteEn = 1'b0;
    step(add_x1(64'd0));

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- LEGv8-subset instruction decode stage for the single-cycle 64-bit CPU; sits between instruction fetch and execute.
- Decodes the 32-bit instruction into datapath control signals and a 64-bit immediate.
- Holds the 32x64 register file and resolves branches: outputs PCSrc and BranchAddress, which fetch uses to select the next PC.

Parameters:
- None (architecture fixed: 32 registers, 64-bit data, 32-bit instruction).

Ports:
- clk  in  1  register-file write clock, rising edge.
- reset  in  1  asynchronous, active-high; clears register file.
- Instruction  in  32  current instruction.
- PC  in  64  byte address of current instruction.
- RegWriteEn  in  1  writeback enable from later stage.
- WriteReg  in  5  writeback destination.
- WriteData  in  64  writeback value.
- PCSrc  out  1  1 = take BranchAddress; 0 = PC+4.
- BranchAddress  out  64  branch target.
- ReadData1  out  64  register Rn (Instruction[9:5]).
- ReadData2  out  64  register Rm or Rt (selected by Reg2Loc).
- Immediate  out  64  extended immediate.
- Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch  out  1 each  control signals.
- ALUOp  out  2  00 add (load/store), 01 pass/compare (CB), 10 R-type funct, 11 immediate arithmetic.
- Halt  out  1  HALT detected.

Behaviour:
- All outputs are purely combinational from Instruction, PC and register contents. There is no pipeline register; the decode latency is zero.
- Opcode match, checked in this priority order:
  - HALT: [31:21] = 11111111111.
  - R-type, matched on [31:21]: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LDUR: [31:21] = 11111000010.
  - STUR: [31:21] = 11111000000.
  - ADDI: [31:22] = 1001000100.
  - SUBI: [31:22] = 1101000100.
  - CBZ: [31:24] = 10110100.
  - CBNZ: [31:24] = 10110101.
  - B: [31:26] = 000101.
  - Anything else is unknown.
- Control signals (any signal not listed is 0):
  - R-type: RegWrite=1, ALUOp=10.
  - LDUR: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00.
  - STUR: Reg2Loc=1, ALUSrc=1, MemWrite=1, ALUOp=00.
  - ADDI/SUBI: ALUSrc=1, RegWrite=1, ALUOp=11.
  - CBZ/CBNZ: Reg2Loc=1, Branch=1, ALUOp=01.
  - B: UncondBranch=1.
  - HALT and unknown opcodes: all controls 0 and PCSrc=0. Halt=1 only for HALT.
- Immediate:
  - ADDI/SUBI: zero-extend [21:10].
  - LDUR/STUR: sign-extend [20:12].
  - CBZ/CBNZ: sign-extend [23:5].
  - B: sign-extend [25:0].
  - All other instructions: 0.
- Register read:
  - ReadData1 = X[Instruction[9:5]].
  - ReadData2 = X[Instruction[4:0]] if Reg2Loc=1, else X[Instruction[20:16]].
  - Reading register 31 (XZR) always returns 0.
- Register write:
  - On the rising edge of clk, when RegWriteEn=1 and WriteReg!=31, X[WriteReg] <= WriteData.
  - Writes to register 31 are discarded.
  - There is no write-to-read bypass: a same-cycle read returns the old value until the edge.
- Reset:
  - Asserting reset clears X0..X30 to 0 immediately, regardless of clk.
  - Writes are blocked while reset is high.
  - Reset mid-operation clears registers but does not affect decode of the current Instruction.
- BranchAddress:
  - BranchAddress = PC + (Immediate << 2), computed modulo 2^64 (wrap-around allowed; negative offsets via two's complement).
  - It is computed for every instruction; it is only meaningful when PCSrc=1.
- PCSrc:
  - PCSrc = UncondBranch | (CBZ & ReadData2==0) | (CBNZ & ReadData2!=0).

Test Plan:
- Reset, then write X1=5 (RegWriteEn=1, WriteReg=1, WriteData=5, one clk edge); decode ADD X2,X1,X1 (0x8B010022) -> ReadData1=ReadData2=5, RegWrite=1, ALUOp=10, PCSrc=0.
- B with imm26=3 at PC=0x10 (0x14000003) -> PCSrc=1, BranchAddress=0x1C, UncondBranch=1; imm26=-1 (0x17FFFFFF) at PC=0x10 -> BranchAddress=0xC.
- CBZ X31, +2 (0xB400005F) at PC=0x40 -> PCSrc=1, BranchAddress=0x48. CBNZ X1 (X1=5), imm19=-2, at PC=0x40 -> PCSrc=1, BranchAddress=0x38. CBZ X1 with X1=5 -> PCSrc=0.
- LDUR X3,[X1,#-8] (imm9=0x1F8) -> Immediate=0xFFFFFFFFFFFFFFF8, MemRead=1, MemtoReg=1, ALUSrc=1. STUR -> Reg2Loc=1, MemWrite=1, RegWrite=0.
- Write X31=0xFF, then read register 31 -> 0. Assert reset asynchronously between edges -> X1 reads 0 immediately.
- HALT (0xFFE00000) -> Halt=1, all controls 0, PCSrc=0. Unknown opcode 0x00000000 -> all controls 0, Halt=0.
